iter_muldiv_wb: RTL and testbench

//  Iterative unsigned 8x8 multiply / 8/8 divide unit with its own writeback sequencer.

---
 rtl/iter_muldiv_wb.sv | 127 ++++++++++++
 tb/tb_iter_muldiv_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_wb.sv
// Iterative unsigned WxW multiply / W/W divide with a two-cycle RegFile writeback.
// Shift-add multiply and restoring divide, one step per CALC cycle.
module iter_muldiv_wb #(
   parameter int unsigned    W       = 8,
   parameter int unsigned    D       = 3,
   parameter logic [D-1:0]   LO_ADDR = D'(0),
   parameter logic [D-1:0]   HI_ADDR = D'(1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Op,
   input  logic [W-1:0]  OperandA,
   input  logic [W-1:0]  OperandB,
   output logic          Busy,
   output logic          Done,
   output logic          DivZero,
   output logic          WriteEn,
   output logic [D-1:0]  Waddr,
   output logic [W-1:0]  DataIn
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      WR_LO,
      WR_HI
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             op_r;
   logic [W-1:0]     b_r;
   logic [2*W-1:0]   mcand;
   logic [2*W-1:0]   acc;

   logic [W:0]       rem_sh;
   logic [W:0]       rem_sub;
   logic             q_bit;
   logic [2*W-1:0]   div_next;
   logic [2*W-1:0]   mul_next;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = CALC;
         CALC:    if (cnt == '0) state_nxt = WR_LO;
         WR_LO:   state_nxt = WR_HI;
         WR_HI:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // acc holds {remainder, dividend/quotient} for divide and the running product for multiply
   always_comb begin
      rem_sh   = {acc[2*W-1:W], acc[W-1]};
      rem_sub  = rem_sh - {1'b0, b_r};
      q_bit    = (rem_sh >= {1'b0, b_r});
      div_next = q_bit ? {rem_sub[W-1:0], acc[W-2:0], 1'b1}
                       : {rem_sh[W-1:0],  acc[W-2:0], 1'b0};
      mul_next = b_r[0] ? (acc + mcand) : acc;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt     <= '0;
         op_r    <= 1'b0;
         b_r     <= '0;
         mcand   <= '0;
         acc     <= '0;
         DivZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  cnt     <= CW'(W - 1);
                  op_r    <= Op;
                  b_r     <= OperandB;
                  mcand   <= {{W{1'b0}}, OperandA};
                  acc     <= Op ? {{W{1'b0}}, OperandA} : '0;
                  DivZero <= Op && (OperandB == '0);
               end
            end
            CALC: begin
               cnt <= cnt - 1'b1;
               if (op_r) begin
                  acc <= div_next;
               end else begin
                  acc   <= mul_next;
                  mcand <= mcand << 1;
                  b_r   <= b_r >> 1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Busy    = (state != IDLE);
      Done    = (state == WR_HI);
      WriteEn = 1'b0;
      Waddr   = '0;
      DataIn  = '0;
      case (state)
         WR_LO: begin
            WriteEn = 1'b1;
            Waddr   = LO_ADDR;
            DataIn  = acc[W-1:0];
         end
         WR_HI: begin
            WriteEn = 1'b1;
            Waddr   = HI_ADDR;
            DataIn  = acc[2*W-1:W];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_iter_muldiv_wb.sv
// Bench for iter_muldiv_wb: transaction-level model checked every cycle plus literal register checks.
module tb_iter_muldiv_wb;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Op;
   logic [7:0] OperandA;
   logic [7:0] OperandB;
   logic       Busy;
   logic       Done;
   logic       DivZero;
   logic       WriteEn;
   logic [2:0] Waddr;
   logic [7:0] DataIn;

   int checks = 0;
   int errors = 0;

   logic [7:0] rf [0:7];
   int         wr_count = 0;

   iter_muldiv_wb #(.W(8), .D(3), .LO_ADDR(3'd0), .HI_ADDR(3'd1)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Op       (Op),
      .OperandA (OperandA),
      .OperandB (OperandB),
      .Busy     (Busy),
      .Done     (Done),
      .DivZero  (DivZero),
      .WriteEn  (WriteEn),
      .Waddr    (Waddr),
      .DataIn   (DataIn)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge Clk) begin
      if (WriteEn) begin
         rf[Waddr] <= DataIn;
         wr_count  <= wr_count + 1;
      end
   end

   // Transaction model: an accepted op occupies 10 cycles; the last two are writes.
   bit         m_active = 0;
   int         m_since  = 0;
   logic [7:0] m_lo = '0, m_hi = '0;
   bit         m_dz = 0;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_active = 0;
         m_since  = 0;
         m_dz     = 0;
      end else if (m_active) begin
         m_since++;
         if (m_since >= 10) m_active = 0;
      end else if (Start) begin
         m_active = 1;
         m_since  = 0;
         m_dz     = Op && (OperandB == 0);
         if (!Op) begin
            {m_hi, m_lo} = 16'(OperandA) * 16'(OperandB);
         end else if (OperandB == 0) begin
            m_lo = 8'hFF;
            m_hi = OperandA;
         end else begin
            m_lo = OperandA / OperandB;
            m_hi = OperandA % OperandB;
         end
      end
   end

   always @(negedge Clk) begin
      automatic bit         e_wr   = m_active && (m_since == 8 || m_since == 9);
      automatic logic [2:0] e_addr = (m_active && m_since == 9) ? 3'd1 : 3'd0;
      automatic logic [7:0] e_data = !e_wr ? 8'h00 : (m_since == 8 ? m_lo : m_hi);
      chk("busy",    16'(Busy),    16'(m_active));
      chk("done",    16'(Done),    16'(m_active && m_since == 9));
      chk("writeen", 16'(WriteEn), 16'(e_wr));
      chk("waddr",   16'(Waddr),   16'(e_addr));
      chk("datain",  16'(DataIn),  16'(e_data));
      chk("divzero", 16'(DivZero), 16'(m_dz));
   end

   task automatic wait_done(output int n);
      n = 1;
      while (!Done && n < 30) begin
         @(negedge Clk);
         n++;
      end
      if (!Done) begin
         errors++;
         $display("FAIL timeout: no Done within %0d cycles", n);
      end
   endtask

   task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b, output int lat);
      rf[0] = 8'hAA;
      rf[1] = 8'hAA;
      @(negedge Clk);
      Op = op; OperandA = a; OperandB = b; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      wait_done(lat);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int lat;
      int wc;
      Reset = 1'b0; Start = 1'b0; Op = 1'b0; OperandA = '0; OperandB = '0;
      for (int i = 0; i < 8; i++) rf[i] = 8'hAA;

      // 1. reset, then 200*3 with latency check
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      chk("rst_busy", 16'(Busy), 16'h0);
      chk("rst_we",   16'(WriteEn), 16'h0);
      chk("rst_data", 16'(DataIn), 16'h0);
      run_op(1'b0, 8'd200, 8'd3, lat);
      chk("mul200x3_lat", 16'(lat), 16'd10);
      chk("mul200x3_r0", 16'(rf[0]), 16'h58);
      chk("mul200x3_r1", 16'(rf[1]), 16'h02);

      // 2. multiply corners
      run_op(1'b0, 8'd255, 8'd255, lat);
      chk("mul255_r0", 16'(rf[0]), 16'h01);
      chk("mul255_r1", 16'(rf[1]), 16'hFE);
      run_op(1'b0, 8'd0, 8'd77, lat);
      chk("mul0_r0", 16'(rf[0]), 16'h00);
      chk("mul0_r1", 16'(rf[1]), 16'h00);
      chk("mul0_dz", 16'(DivZero), 16'h0);

      // 3. divides
      run_op(1'b1, 8'd200, 8'd7, lat);
      chk("div200_7_r0", 16'(rf[0]), 16'h1C);
      chk("div200_7_r1", 16'(rf[1]), 16'h04);
      run_op(1'b1, 8'd5, 8'd9, lat);
      chk("div5_9_r0", 16'(rf[0]), 16'h00);
      chk("div5_9_r1", 16'(rf[1]), 16'h05);

      // 4. divide by zero, then cleared by next accepted Start
      run_op(1'b1, 8'd123, 8'd0, lat);
      chk("div0_r0", 16'(rf[0]), 16'hFF);
      chk("div0_r1", 16'(rf[1]), 16'h7B);
      chk("div0_dz", 16'(DivZero), 16'h1);
      run_op(1'b0, 8'd6, 8'd7, lat);
      chk("dz_clr", 16'(DivZero), 16'h0);
      chk("mul6x7_r0", 16'(rf[0]), 16'h2A);

      // 5. Start held high through an operation with changing operands
      rf[0] = 8'hAA; rf[1] = 8'hAA;
      @(negedge Clk);
      wc = wr_count;
      Op = 1'b0; OperandA = 8'd10; OperandB = 8'd20; Start = 1'b1;
      @(negedge Clk);
      lat = 1;
      while (!Done && lat < 30) begin
         OperandA = OperandA + 8'd13;
         OperandB = OperandB + 8'd7;
         Op = ~Op;
         @(negedge Clk);
         lat++;
      end
      chk("hold_lat", 16'(lat), 16'd10);
      @(negedge Clk);
      chk("hold_idle", 16'(Busy), 16'h0);
      chk("hold_r0", 16'(rf[0]), 16'hC8);
      chk("hold_r1", 16'(rf[1]), 16'h00);
      chk("hold_wrcnt", 16'(wr_count - wc), 16'd2);
      // back-to-back: Start presented in the first IDLE cycle is accepted
      Op = 1'b0; OperandA = 8'd3; OperandB = 8'd4; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      chk("b2b_busy", 16'(Busy), 16'h1);
      wait_done(lat);
      @(posedge Clk);
      #1;
      chk("b2b_r0", 16'(rf[0]), 16'h0C);

      // 6. async reset during CALC aborts without any write
      @(negedge Clk);
      wc = wr_count;
      Op = 1'b0; OperandA = 8'd50; OperandB = 8'd50; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("abort_busy", 16'(Busy), 16'h0);
      chk("abort_we",   16'(WriteEn), 16'h0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (12) @(negedge Clk);
      chk("abort_nowr", 16'(wr_count - wc), 16'd0);
      run_op(1'b0, 8'd2, 8'd2, lat);
      chk("mul2x2_r0", 16'(rf[0]), 16'h04);
      chk("mul2x2_r1", 16'(rf[1]), 16'h00);

      repeat (2) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
